// File: rtl/spi_regbank_sl_if.sv
// -----------------------------------------------------------------------------
// spi_regbank_sl_if
// SPI pin bundle between an SPI master (or pad ring) and spi_regbank_sl.
//
// Signals:
//   sclk      SPI clock (asynchronous to the system clock)
//   cs_n      chip select, active low
//   mosi      master-out / slave-in serial data
//   spi_mode  {CPOL, CPHA}; quasi-static, sampled at the start of a frame
//   miso      master-in / slave-out serial data
//   miso_oe   tri-state enable for the miso pad
// -----------------------------------------------------------------------------
interface spi_regbank_sl_if;
   logic       sclk;
   logic       cs_n;
   logic       mosi;
   logic [1:0] spi_mode;
   logic       miso;
   logic       miso_oe;

   modport master (
      output sclk, cs_n, mosi, spi_mode,
      input  miso, miso_oe
   );

   modport slave (
      input  sclk, cs_n, mosi, spi_mode,
      output miso, miso_oe
   );
endinterface

// File: rtl/spi_regbank_sl.sv
// -----------------------------------------------------------------------------
// spi_regbank_sl
// SPI slave register bank. The SPI pins are oversampled in the sys_clk domain
// (2-FF synchronisers plus edge detection), so the whole block runs on one
// clock. Frames are MSB first: RWb (1 = read), ADDR, DATA. Read data is
// returned in the same frame; writes commit when cs_n rises after exactly
// FRAME_W sampled bits. Register 0 is a read-only ID.
//
// Ports:
//   sys_clk    system clock, sole clock
//   rstn       synchronous active-low reset
//   spi        SPI pins (slave modport of spi_regbank_sl_if)
//   reg_q      flattened register contents, reg i at [i*DATA_W +: DATA_W]
//   wr_stb     one-cycle pulse on a committed write
//   wr_addr    address of the last committed write
//   frame_err  one-cycle pulse: frame length differs from FRAME_W
//   addr_err   one-cycle pulse: address >= NUM_REGS
// -----------------------------------------------------------------------------
module spi_regbank_sl #(
   parameter int                ADDR_W   = 6,
   parameter int                DATA_W   = 16,
   parameter int                NUM_REGS = 16,
   parameter logic [DATA_W-1:0] ID_VAL   = 16'hA5C3
) (
   input  logic                         sys_clk,
   input  logic                         rstn,
   spi_regbank_sl_if.slave              spi,
   output logic [NUM_REGS*DATA_W-1:0]   reg_q,
   output logic                         wr_stb,
   output logic [ADDR_W-1:0]            wr_addr,
   output logic                         frame_err,
   output logic                         addr_err
);

   localparam int FRAME_W = 1 + ADDR_W + DATA_W;
   localparam int CNT_W   = $clog2(FRAME_W + 2);
   localparam int SH_W    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam logic [ADDR_W:0]  NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);
   localparam logic [CNT_W-1:0] CNT_CMD    = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0] CNT_FRAME  = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(FRAME_W + 1);

   typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

   // Synchronisers and delayed copies for edge detection
   logic [1:0] sclk_sync, cs_sync, mosi_sync, mode_m, mode_s;
   logic       sclk_d, cs_d;

   state_t              state;
   logic [CNT_W-1:0]    bit_cnt;
   logic                cpol, cpha;
   logic [SH_W-1:0]     shift_in;
   logic [DATA_W-1:0]   shift_out;
   logic                rwb;
   logic [ADDR_W-1:0]   addr;
   logic [DATA_W-1:0]   regs [1:NUM_REGS-1];

   logic sclk_s, cs_s, mosi_s;
   logic sclk_rise, sclk_fall, lead_edge, trail_edge;
   logic sample_edge, shift_edge, cs_fall, cs_rise;
   logic [ADDR_W:0]     cmd_word;

   assign sclk_s = sclk_sync[1];
   assign cs_s   = cs_sync[1];
   assign mosi_s = mosi_sync[1];

   assign sclk_rise  = sclk_s & ~sclk_d;
   assign sclk_fall  = ~sclk_s & sclk_d;
   assign lead_edge  = cpol ? sclk_fall : sclk_rise;
   assign trail_edge = cpol ? sclk_rise : sclk_fall;
   // sclk activity while cs_n is deasserted never reaches the frame logic
   assign sample_edge = (cpha ? trail_edge : lead_edge) & ~cs_s;
   assign shift_edge  = (cpha ? lead_edge : trail_edge) & ~cs_s;

   assign cs_fall = cs_d & ~cs_s;
   assign cs_rise = ~cs_d & cs_s;

   // RWb and ADDR as they stand on the last command sample: ADDR_W earlier
   // bits already shifted in plus the bit being sampled now.
   assign cmd_word = {shift_in[ADDR_W-1:0], mosi_s};

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < NUM_REGS_L;
   endfunction

   function automatic logic [DATA_W-1:0] reg_read(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] r;
      r = '0;
      if (a == '0) r = ID_VAL;
      for (int i = 1; i < NUM_REGS; i++)
         if (a == ADDR_W'(i)) r = regs[i];
      return r;
   endfunction

   always_comb begin
      reg_q = '0;
      reg_q[DATA_W-1:0] = ID_VAL;
      for (int i = 1; i < NUM_REGS; i++)
         reg_q[i*DATA_W +: DATA_W] = regs[i];
   end

   // NOTE: every register here, including the register file, is cleared by
   // the synchronous reset and updated only with non-blocking assignments so
   // all reads within a cycle see pre-edge values.
   always_ff @(posedge sys_clk) begin
      if (!rstn) begin
         sclk_sync <= '0;
         mosi_sync <= '0;
         // cs_n history resets to "asserted": a frame can only start after
         // cs_n has been seen high, so a reset mid-frame is not re-entered.
         cs_sync   <= '0;
         cs_d      <= 1'b0;
         sclk_d    <= 1'b0;
         mode_m    <= '0;
         mode_s    <= '0;
         state     <= IDLE;
         bit_cnt   <= '0;
         cpol      <= 1'b0;
         cpha      <= 1'b0;
         shift_in  <= '0;
         shift_out <= '0;
         rwb       <= 1'b0;
         addr      <= '0;
         spi.miso    <= 1'b0;
         spi.miso_oe <= 1'b0;
         wr_stb    <= 1'b0;
         wr_addr   <= '0;
         frame_err <= 1'b0;
         addr_err  <= 1'b0;
         for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         sclk_sync <= {sclk_sync[0], spi.sclk};
         cs_sync   <= {cs_sync[0], spi.cs_n};
         mosi_sync <= {mosi_sync[0], spi.mosi};
         mode_m    <= spi.spi_mode;
         mode_s    <= mode_m;
         sclk_d    <= sclk_s;
         cs_d      <= cs_s;

         wr_stb    <= 1'b0;
         frame_err <= 1'b0;
         addr_err  <= 1'b0;

         // cs_n rise takes priority over any sclk edge in the same cycle
         if (state != IDLE && cs_rise) begin
            state       <= IDLE;
            spi.miso    <= 1'b0;
            spi.miso_oe <= 1'b0;
            if (bit_cnt != CNT_FRAME) begin
               frame_err <= 1'b1;
            end else if (!rwb) begin
               if (!in_range(addr)) begin
                  addr_err <= 1'b1;
               end else if (addr != '0) begin
                  for (int i = 1; i < NUM_REGS; i++)
                     if (addr == ADDR_W'(i)) regs[i] <= shift_in[DATA_W-1:0];
                  wr_stb  <= 1'b1;
                  wr_addr <= addr;
               end
            end
         end else begin
            case (state)
               IDLE: begin
                  if (cs_fall) begin
                     cpol        <= mode_s[1];
                     cpha        <= mode_s[0];
                     bit_cnt     <= '0;
                     spi.miso    <= 1'b0;
                     spi.miso_oe <= 1'b1;
                     state       <= CMD;
                  end
               end
               CMD: begin
                  if (sample_edge) begin
                     shift_in <= {shift_in[SH_W-2:0], mosi_s};
                     bit_cnt  <= bit_cnt + 1'b1;
                     if (bit_cnt == CNT_CMD) begin
                        rwb       <= cmd_word[ADDR_W];
                        addr      <= cmd_word[ADDR_W-1:0];
                        // Write frames load zeros so miso stays low throughout
                        shift_out <= cmd_word[ADDR_W] ? reg_read(cmd_word[ADDR_W-1:0]) : '0;
                        if (cmd_word[ADDR_W] && !in_range(cmd_word[ADDR_W-1:0]))
                           addr_err <= 1'b1;
                        state <= DATA;
                     end
                  end
               end
               DATA: begin
                  if (sample_edge) begin
                     shift_in <= {shift_in[SH_W-2:0], mosi_s};
                     if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
                  end
                  if (shift_edge) begin
                     spi.miso  <= shift_out[DATA_W-1];
                     shift_out <= {shift_out[DATA_W-2:0], 1'b0};
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_regbank_sl.sv
// -----------------------------------------------------------------------------
// tb_spi_regbank_sl
// Directed bench for spi_regbank_sl: a bit-banged SPI master driven at
// sys_clk/16, a pulse monitor, and a register model of the expected contents.
// -----------------------------------------------------------------------------
module tb_spi_regbank_sl;
   localparam int ADDR_W   = 6;
   localparam int DATA_W   = 16;
   localparam int NUM_REGS = 16;
   localparam logic [15:0] ID = 16'hA5C3;
   localparam int H = 8;   // sys_clk cycles per sclk half period

   logic sys_clk = 1'b0;
   logic rstn;
   always #5 sys_clk = ~sys_clk;

   spi_regbank_sl_if spi();

   logic [NUM_REGS*DATA_W-1:0] reg_q;
   logic                       wr_stb;
   logic [ADDR_W-1:0]          wr_addr;
   logic                       frame_err;
   logic                       addr_err;

   spi_regbank_sl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ID_VAL(ID)
   ) dut (
      .sys_clk   (sys_clk),
      .rstn      (rstn),
      .spi       (spi.slave),
      .reg_q     (reg_q),
      .wr_stb    (wr_stb),
      .wr_addr   (wr_addr),
      .frame_err (frame_err),
      .addr_err  (addr_err)
   );

   int checks = 0;
   int failures = 0;

   // Pulse monitor
   int n_wr = 0, n_ferr = 0, n_aerr = 0;
   logic [ADDR_W-1:0] last_wr_addr = '0;
   always @(negedge sys_clk) begin
      if (wr_stb) begin
         n_wr = n_wr + 1;
         last_wr_addr = wr_addr;
      end
      if (frame_err) n_ferr = n_ferr + 1;
      if (addr_err)  n_aerr = n_aerr + 1;
   end

   logic [15:0] model [NUM_REGS];
   logic        oe_mid;
   logic [31:0] rx;
   logic [31:0] f;
   int w0, fe0, ae0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      logic [NUM_REGS*DATA_W-1:0] exp;
      exp = '0;
      exp[15:0] = ID;
      for (int i = 1; i < NUM_REGS; i++) exp[i*DATA_W +: DATA_W] = model[i];
      checks++;
      assert (reg_q === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, reg_q, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic snap();
      w0 = n_wr; fe0 = n_ferr; ae0 = n_aerr;
   endtask

   task automatic cs_low(input logic [1:0] mode);
      spi.spi_mode = mode;
      spi.sclk = mode[1];
      wait_clk(H);
      spi.cs_n = 1'b0;
      wait_clk(H);
   endtask

   task automatic cs_high();
      wait_clk(H);
      spi.cs_n = 1'b1;
      wait_clk(H);
   endtask

   // Clocks nbits of 'bits' (MSB = bits[nbits-1]) and collects miso at each
   // sample edge.
   task automatic spi_bits(input logic [1:0] mode, input int nbits,
                           input logic [31:0] bits, output logic [31:0] r);
      r = '0;
      for (int i = 0; i < nbits; i++) begin
         if (!mode[0]) begin
            spi.mosi = bits[nbits-1-i];
            wait_clk(H);
            r = {r[30:0], spi.miso};
            spi.sclk = ~mode[1];
            wait_clk(H);
            spi.sclk = mode[1];
         end else begin
            spi.sclk = ~mode[1];
            spi.mosi = bits[nbits-1-i];
            wait_clk(H);
            r = {r[30:0], spi.miso};
            spi.sclk = mode[1];
            wait_clk(H);
         end
         if (i == nbits / 2) oe_mid = spi.miso_oe;
      end
   endtask

   task automatic xfer(input logic [1:0] mode, input int nbits,
                       input logic [31:0] bits, output logic [31:0] r);
      cs_low(mode);
      spi_bits(mode, nbits, bits, r);
      cs_high();
   endtask

   function automatic logic [31:0] frm(input logic rw, input logic [5:0] a, input logic [15:0] d);
      return {9'b0, rw, a, d};
   endfunction

   initial begin
      spi.sclk = 1'b0; spi.cs_n = 1'b1; spi.mosi = 1'b0; spi.spi_mode = 2'd0;
      oe_mid = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      rstn = 1'b0;
      wait_clk(4);

      // Reset state
      check_regs("reset_regs");
      check("reset_miso", 32'(spi.miso), 32'd0);
      check("reset_miso_oe", 32'(spi.miso_oe), 32'd0);
      check("reset_wr_stb", 32'(wr_stb), 32'd0);
      check("reset_wr_addr", 32'(wr_addr), 32'd0);
      check("reset_frame_err", 32'(frame_err), 32'd0);
      check("reset_addr_err", 32'(addr_err), 32'd0);
      rstn = 1'b1;
      wait_clk(4);

      // Mode 0 write addr 3
      snap();
      xfer(2'd0, 23, frm(1'b0, 6'd3, 16'h1234), rx);
      model[3] = 16'h1234;
      check("w3_wr_stb_count", n_wr - w0, 1);
      check("w3_wr_addr", 32'(last_wr_addr), 32'd3);
      check_regs("w3_regs");
      check("w3_frame_err", n_ferr - fe0, 0);
      check("w3_addr_err", n_aerr - ae0, 0);
      check("w3_oe_mid", 32'(oe_mid), 32'd1);
      check("w3_oe_after", 32'(spi.miso_oe), 32'd0);

      // Mode 3 read addr 3: 7 command bits of zero then the data
      snap();
      xfer(2'd3, 23, frm(1'b1, 6'd3, 16'h0000), rx);
      check("r3_mode3_data", rx, 32'h0000_1234);
      check("r3_oe_mid", 32'(oe_mid), 32'd1);
      check("r3_oe_after", 32'(spi.miso_oe), 32'd0);
      check("r3_no_write", n_wr - w0, 0);
      check("r3_no_err", (n_ferr - fe0) + (n_aerr - ae0), 0);

      // ID register in modes 1 and 2
      xfer(2'd1, 23, frm(1'b1, 6'd0, 16'h0000), rx);
      check("r0_mode1", rx, 32'h0000_A5C3);
      xfer(2'd2, 23, frm(1'b1, 6'd0, 16'h0000), rx);
      check("r0_mode2", rx, 32'h0000_A5C3);

      // Write to the ID register is dropped silently
      snap();
      xfer(2'd0, 23, frm(1'b0, 6'd0, 16'hFFFF), rx);
      check("w0_no_wr_stb", n_wr - w0, 0);
      check("w0_no_err", (n_ferr - fe0) + (n_aerr - ae0), 0);
      check_regs("w0_regs");
      xfer(2'd0, 23, frm(1'b1, 6'd0, 16'h0000), rx);
      check("w0_reread_id", rx, 32'h0000_A5C3);

      // Out-of-range address
      snap();
      xfer(2'd1, 23, frm(1'b0, 6'd20, 16'hBEEF), rx);
      check("w20_addr_err", n_aerr - ae0, 1);
      check("w20_no_wr_stb", n_wr - w0, 0);
      check_regs("w20_regs");
      snap();
      xfer(2'd2, 23, frm(1'b1, 6'd20, 16'h0000), rx);
      check("r20_data_zero", rx, 32'h0);
      check("r20_addr_err", n_aerr - ae0, 1);

      // Short (22-bit) and long (24-bit) write frames to addr 5
      f = frm(1'b0, 6'd5, 16'hCAFE);
      snap();
      xfer(2'd0, 22, f >> 1, rx);
      check("short_frame_err", n_ferr - fe0, 1);
      check("short_no_wr", n_wr - w0, 0);
      check_regs("short_regs");
      snap();
      xfer(2'd0, 24, f << 1, rx);
      check("long_frame_err", n_ferr - fe0, 1);
      check("long_no_wr", n_wr - w0, 0);
      check_regs("long_regs");

      // Reset after 10 bits of a write frame, then finish the frame
      f = frm(1'b0, 6'd7, 16'h5A5A);
      snap();
      cs_low(2'd0);
      spi_bits(2'd0, 10, f >> 13, rx);
      rstn = 1'b0;
      wait_clk(3);
      rstn = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      spi_bits(2'd0, 13, f & 32'h1FFF, rx);
      cs_high();
      check("rst_mid_no_wr", n_wr - w0, 0);
      check("rst_mid_no_frame_err", n_ferr - fe0, 0);
      check_regs("rst_mid_regs");

      snap();
      xfer(2'd0, 23, f, rx);
      model[7] = 16'h5A5A;
      check("post_rst_wr_stb", n_wr - w0, 1);
      check("post_rst_wr_addr", 32'(last_wr_addr), 32'd7);
      check_regs("post_rst_regs");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
